// File: rtl/mem_stage.sv
// MEM stage of the toy MIPS pipeline: lw/lb/lbu/sw/sb over a variable-latency req/ack
// data-memory port, with stall request, ack timeout and registered MEM/WB outputs.
module mem_stage #(
   parameter int ACK_TIMEOUT = 16
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [5:0]  stall_i,
   input  logic [5:0]  op_i,
   input  logic [31:0] F_i,
   input  logic [31:0] B_i,
   input  logic        rw_en_i,
   input  logic [4:0]  rw_i,
   output logic        dmem_req_o,
   output logic        dmem_we_o,
   output logic [31:0] dmem_addr_o,
   output logic [31:0] dmem_wdata_o,
   output logic [3:0]  dmem_be_o,
   input  logic [31:0] dmem_rdata_i,
   input  logic        dmem_ack_i,
   output logic        stallreq_o,
   output logic        rw_en_o,
   output logic [4:0]  rw_o,
   output logic [31:0] wdata_o,
   output logic        addr_err_o,
   output logic        bus_err_o
);

   localparam logic [5:0] OP_LW  = 6'b100011;
   localparam logic [5:0] OP_LB  = 6'b100000;
   localparam logic [5:0] OP_LBU = 6'b100100;
   localparam logic [5:0] OP_SW  = 6'b101011;
   localparam logic [5:0] OP_SB  = 6'b101000;
   localparam int         CW     = $clog2(ACK_TIMEOUT + 1);

   typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, HOLD = 2'd2} state_t;
   typedef enum logic [1:0] {LD_W = 2'd0, LD_B = 2'd1, LD_BU = 2'd2} ld_kind_t;

   state_t        state_q, state_d;
   ld_kind_t      ld_kind_q, ld_kind_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          req_q, req_d, we_q, we_d;
   logic [31:0]   addr_q, addr_d, wdat_q, wdat_d;
   logic [3:0]    be_q, be_d;
   logic [1:0]    k_q, k_d;
   logic          is_load_q, is_load_d;
   logic [31:0]   ld_data_q, ld_data_d;
   logic          err_q, err_d;

   logic          wb_rw_en_q, wb_addr_err_q, wb_bus_err_q;
   logic [4:0]    wb_rw_q;
   logic [31:0]   wb_wdata_q;

   logic          is_lw, is_lb, is_lbu, is_sw, is_sb, is_load, is_mem, misalign;
   logic          wb_ready, wb_addr_err, wb_bus_err;
   logic [31:0]   wb_wdata;
   logic          unused_stall;

   assign unused_stall = ^stall_i[3:0];

   assign is_lw    = (op_i == OP_LW);
   assign is_lb    = (op_i == OP_LB);
   assign is_lbu   = (op_i == OP_LBU);
   assign is_sw    = (op_i == OP_SW);
   assign is_sb    = (op_i == OP_SB);
   assign is_load  = is_lw | is_lb | is_lbu;
   assign is_mem   = is_load | is_sw | is_sb;
   assign misalign = (is_lw | is_sw) & (F_i[1:0] != 2'b00);

   function automatic logic [31:0] fmt_load(input ld_kind_t kind, input logic [1:0] k,
                                            input logic [31:0] rdata);
      logic [7:0] b;
      case (k)
         2'd0:    b = rdata[7:0];
         2'd1:    b = rdata[15:8];
         2'd2:    b = rdata[23:16];
         default: b = rdata[31:24];
      endcase
      case (kind)
         LD_B:    fmt_load = {{24{b[7]}}, b};
         LD_BU:   fmt_load = {24'h000000, b};
         default: fmt_load = rdata;
      endcase
   endfunction

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         ld_kind_q <= LD_W;
         cnt_q     <= '0;
         req_q     <= 1'b0;
         we_q      <= 1'b0;
         addr_q    <= '0;
         wdat_q    <= '0;
         be_q      <= '0;
         k_q       <= '0;
         is_load_q <= 1'b0;
         ld_data_q <= '0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         ld_kind_q <= ld_kind_d;
         cnt_q     <= cnt_d;
         req_q     <= req_d;
         we_q      <= we_d;
         addr_q    <= addr_d;
         wdat_q    <= wdat_d;
         be_q      <= be_d;
         k_q       <= k_d;
         is_load_q <= is_load_d;
         ld_data_q <= ld_data_d;
         err_q     <= err_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      ld_kind_d  = ld_kind_q;
      cnt_d      = cnt_q;
      req_d      = req_q;
      we_d       = we_q;
      addr_d     = addr_q;
      wdat_d     = wdat_q;
      be_d       = be_q;
      k_d        = k_q;
      is_load_d  = is_load_q;
      ld_data_d  = ld_data_q;
      err_d      = err_q;
      stallreq_o = 1'b0;
      wb_ready   = 1'b0;
      case (state_q)
         IDLE: begin
            if (is_mem && !misalign) begin
               stallreq_o = 1'b1;
               state_d    = REQ;
               req_d      = 1'b1;
               we_d       = is_sw | is_sb;
               addr_d     = {F_i[31:2], 2'b00};
               be_d       = is_sb ? (4'b0001 << F_i[1:0]) : 4'hF;
               wdat_d     = is_sb ? {4{B_i[7:0]}} : B_i;
               k_d        = F_i[1:0];
               is_load_d  = is_load;
               ld_kind_d  = is_lb ? LD_B : (is_lbu ? LD_BU : LD_W);
               ld_data_d  = '0;
               cnt_d      = '0;
               err_d      = 1'b0;
            end else begin
               wb_ready = 1'b1;
            end
         end
         REQ: begin
            stallreq_o = 1'b1;
            // Ack is checked before expiry so a same-cycle ack completes without error.
            if (dmem_ack_i) begin
               ld_data_d = fmt_load(ld_kind_q, k_q, dmem_rdata_i);
               req_d     = 1'b0;
               state_d   = HOLD;
            end else if (cnt_q == CW'(ACK_TIMEOUT - 1)) begin
               req_d   = 1'b0;
               err_d   = 1'b1;
               state_d = HOLD;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         HOLD: begin
            wb_ready = 1'b1;
            if (!stall_i[4]) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign wb_addr_err = (state_q == IDLE) & misalign;
   assign wb_bus_err  = (state_q == HOLD) & err_q;
   assign wb_wdata    = ((state_q == HOLD) && is_load_q) ? ld_data_q : F_i;

   // A result that is not ready yet enters WB as a bubble rather than a stale value.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wb_rw_en_q    <= 1'b0;
         wb_rw_q       <= '0;
         wb_wdata_q    <= '0;
         wb_addr_err_q <= 1'b0;
         wb_bus_err_q  <= 1'b0;
      end else if (!(stall_i[4] && stall_i[5])) begin
         if (stall_i[4] || !wb_ready) begin
            wb_rw_en_q    <= 1'b0;
            wb_addr_err_q <= 1'b0;
            wb_bus_err_q  <= 1'b0;
         end else begin
            wb_rw_en_q    <= rw_en_i & ~wb_addr_err & ~wb_bus_err;
            wb_rw_q       <= rw_i;
            wb_wdata_q    <= wb_wdata;
            wb_addr_err_q <= wb_addr_err;
            wb_bus_err_q  <= wb_bus_err;
         end
      end
   end

   assign dmem_req_o   = req_q;
   assign dmem_we_o    = we_q;
   assign dmem_addr_o  = addr_q;
   assign dmem_wdata_o = wdat_q;
   assign dmem_be_o    = be_q;
   assign rw_en_o      = wb_rw_en_q;
   assign rw_o         = wb_rw_q;
   assign wdata_o      = wb_wdata_q;
   assign addr_err_o   = wb_addr_err_q;
   assign bus_err_o    = wb_bus_err_q;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: pass-through, loads, stores, misalignment, timeout,
// reset mid-access, MEM/WB hold/bubble and back-to-back accesses.
module tb_mem_stage;

   localparam logic [5:0] OP_NOP = 6'b000000;
   localparam logic [5:0] OP_LW  = 6'b100011;
   localparam logic [5:0] OP_LB  = 6'b100000;
   localparam logic [5:0] OP_LBU = 6'b100100;
   localparam logic [5:0] OP_SW  = 6'b101011;
   localparam logic [5:0] OP_SB  = 6'b101000;

   logic        clk, rst_n;
   logic [5:0]  stall_i, op_i;
   logic [31:0] F_i, B_i, dmem_rdata_i;
   logic        rw_en_i, dmem_ack_i;
   logic [4:0]  rw_i;
   logic        dmem_req_o, dmem_we_o, stallreq_o, rw_en_o, addr_err_o, bus_err_o;
   logic [31:0] dmem_addr_o, dmem_wdata_o, wdata_o;
   logic [3:0]  dmem_be_o;
   logic [4:0]  rw_o;
   logic        stall4_tb, stall5_tb;

   int n_cmp = 0;
   int n_fail = 0;

   // Pipeline controller model: MEM is held whenever the stage requests it.
   assign stall_i = {stall5_tb, stallreq_o | stall4_tb, 4'b0000};

   mem_stage #(.ACK_TIMEOUT(16)) dut (
      .clk(clk), .rst_n(rst_n), .stall_i(stall_i), .op_i(op_i), .F_i(F_i), .B_i(B_i),
      .rw_en_i(rw_en_i), .rw_i(rw_i), .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o),
      .dmem_addr_o(dmem_addr_o), .dmem_wdata_o(dmem_wdata_o), .dmem_be_o(dmem_be_o),
      .dmem_rdata_i(dmem_rdata_i), .dmem_ack_i(dmem_ack_i), .stallreq_o(stallreq_o),
      .rw_en_o(rw_en_o), .rw_o(rw_o), .wdata_o(wdata_o), .addr_err_o(addr_err_o),
      .bus_err_o(bus_err_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Drives one op, answers the request with an ack on the ack_n-th REQ cycle
   // (0 = never) and returns at the negedge after the result edge.
   task automatic run_mem(input logic [5:0] op, input logic [31:0] f, input logic [31:0] b,
                          input logic [31:0] rdata, input int ack_n, input bit chain,
                          output int n_stall, output int n_req, output logic [31:0] addr,
                          output logic [31:0] wd, output logic we, output logic [3:0] be,
                          output bit done);
      if (!chain) @(negedge clk);
      op_i = op; F_i = f; B_i = b; rw_en_i = 1'b1; rw_i = 5'd9;
      n_stall = 0; n_req = 0; done = 1'b0;
      addr = '0; wd = '0; we = 1'b0; be = '0;
      for (int c = 0; c < 40 && !done; c++) begin
         #1;
         if (dmem_req_o) begin
            n_req++;
            if (n_req == 1) begin
               addr = dmem_addr_o; wd = dmem_wdata_o; we = dmem_we_o; be = dmem_be_o;
            end
            dmem_ack_i   = (n_req == ack_n);
            dmem_rdata_i = dmem_ack_i ? rdata : 32'h0;
         end else begin
            dmem_ack_i = 1'b0; dmem_rdata_i = 32'h0;
         end
         if (stallreq_o) n_stall++;
         else done = 1'b1;
         @(negedge clk);
      end
      dmem_ack_i = 1'b0; dmem_rdata_i = 32'h0; op_i = OP_NOP;
   endtask

   task automatic test_reset;
      rst_n = 1'b0; stall4_tb = 1'b0; stall5_tb = 1'b0;
      op_i = OP_NOP; F_i = '0; B_i = '0; rw_en_i = 1'b0; rw_i = '0;
      dmem_ack_i = 1'b0; dmem_rdata_i = '0;
      repeat (2) @(negedge clk);
      n_cmp++; if ({dmem_req_o, dmem_we_o, dmem_be_o} !== 6'b0) begin n_fail++;
         $display("FAIL reset_dmem_ctl: got %b expected 000000", {dmem_req_o, dmem_we_o, dmem_be_o}); end
      n_cmp++; if ({dmem_addr_o, dmem_wdata_o} !== 64'h0) begin n_fail++;
         $display("FAIL reset_dmem_data: got %h expected 0", {dmem_addr_o, dmem_wdata_o}); end
      n_cmp++; if ({rw_en_o, rw_o, wdata_o, addr_err_o, bus_err_o} !== 40'h0) begin n_fail++;
         $display("FAIL reset_wb: got %h expected 0", {rw_en_o, rw_o, wdata_o, addr_err_o, bus_err_o}); end
      n_cmp++; if (stallreq_o !== 1'b0) begin n_fail++;
         $display("FAIL reset_stallreq: got %b expected 0", stallreq_o); end
      rst_n = 1'b1;
   endtask

   task automatic test_passthrough;
      @(negedge clk);
      op_i = OP_NOP; F_i = 32'h12345678; rw_en_i = 1'b1; rw_i = 5'd5;
      #1;
      n_cmp++; if (stallreq_o !== 1'b0) begin n_fail++;
         $display("FAIL pass_stallreq: got %b expected 0", stallreq_o); end
      @(negedge clk);
      n_cmp++; if ({rw_en_o, rw_o, wdata_o} !== {1'b1, 5'd5, 32'h12345678}) begin n_fail++;
         $display("FAIL pass_wb: got %h expected %h", {rw_en_o, rw_o, wdata_o}, {1'b1, 5'd5, 32'h12345678}); end
      n_cmp++; if (dmem_req_o !== 1'b0) begin n_fail++;
         $display("FAIL pass_noreq: got %b expected 0", dmem_req_o); end
   endtask

   task automatic test_lw;
      int ns, nr; logic [31:0] a, wd; logic we; logic [3:0] be; bit done;
      run_mem(OP_LW, 32'h100, 32'h0, 32'hDEADBEEF, 2, 1'b0, ns, nr, a, wd, we, be, done);
      n_cmp++; if (done !== 1'b1) begin n_fail++; $display("FAIL lw_done: got %b expected 1", done); end
      n_cmp++; if ({a, we} !== {32'h100, 1'b0}) begin n_fail++;
         $display("FAIL lw_bus: got addr %h we %b expected 100 0", a, we); end
      n_cmp++; if (ns !== 3 || nr !== 2) begin n_fail++;
         $display("FAIL lw_cycles: got stall %0d req %0d expected 3 2", ns, nr); end
      n_cmp++; if ({rw_en_o, rw_o, wdata_o} !== {1'b1, 5'd9, 32'hDEADBEEF}) begin n_fail++;
         $display("FAIL lw_wb: got %h expected %h", {rw_en_o, rw_o, wdata_o}, {1'b1, 5'd9, 32'hDEADBEEF}); end
   endtask

   task automatic test_byte_loads;
      int ns, nr; logic [31:0] a, wd; logic we; logic [3:0] be; bit done;
      run_mem(OP_LB, 32'h103, 32'h0, 32'h80AABBCC, 1, 1'b0, ns, nr, a, wd, we, be, done);
      n_cmp++; if (wdata_o !== 32'hFFFFFF80 || ns !== 2) begin n_fail++;
         $display("FAIL lb_b3: got %h stall %0d expected ffffff80 2", wdata_o, ns); end
      run_mem(OP_LBU, 32'h103, 32'h0, 32'h80AABBCC, 3, 1'b0, ns, nr, a, wd, we, be, done);
      n_cmp++; if (wdata_o !== 32'h00000080 || ns !== 4) begin n_fail++;
         $display("FAIL lbu_b3: got %h stall %0d expected 00000080 4", wdata_o, ns); end
      run_mem(OP_LB, 32'h100, 32'h0, 32'h80AABBCC, 1, 1'b0, ns, nr, a, wd, we, be, done);
      n_cmp++; if (wdata_o !== 32'hFFFFFFCC) begin n_fail++;
         $display("FAIL lb_b0: got %h expected ffffffcc", wdata_o); end
      run_mem(OP_LBU, 32'h101, 32'h0, 32'h80AABBCC, 1, 1'b0, ns, nr, a, wd, we, be, done);
      n_cmp++; if (wdata_o !== 32'h000000BB || a !== 32'h100) begin n_fail++;
         $display("FAIL lbu_b1: got %h addr %h expected 000000bb 100", wdata_o, a); end
      run_mem(OP_LB, 32'h102, 32'h0, 32'h807A0000, 1, 1'b0, ns, nr, a, wd, we, be, done);
      n_cmp++; if (wdata_o !== 32'h0000007A) begin n_fail++;
         $display("FAIL lb_pos: got %h expected 0000007a", wdata_o); end
   endtask

   task automatic test_stores;
      int ns, nr; logic [31:0] a, wd; logic we; logic [3:0] be; bit done;
      run_mem(OP_SB, 32'h102, 32'h12345655, 32'h0, 1, 1'b0, ns, nr, a, wd, we, be, done);
      n_cmp++; if ({we, be, wd, a} !== {1'b1, 4'b0100, 32'h55555555, 32'h100}) begin n_fail++;
         $display("FAIL sb_bus: got we %b be %b wd %h addr %h expected 1 0100 55555555 100", we, be, wd, a); end
      n_cmp++; if ({rw_en_o, wdata_o} !== {1'b1, 32'h102}) begin n_fail++;
         $display("FAIL sb_wb: got %h expected %h", {rw_en_o, wdata_o}, {1'b1, 32'h102}); end
      run_mem(OP_SW, 32'h204, 32'hCAFEF00D, 32'h0, 2, 1'b0, ns, nr, a, wd, we, be, done);
      n_cmp++; if ({we, be, wd, a} !== {1'b1, 4'hF, 32'hCAFEF00D, 32'h204}) begin n_fail++;
         $display("FAIL sw_bus: got we %b be %h wd %h addr %h expected 1 f cafef00d 204", we, be, wd, a); end
   endtask

   task automatic test_misaligned;
      int ns, nr; logic [31:0] a, wd; logic we; logic [3:0] be; bit done;
      run_mem(OP_LW, 32'h102, 32'h0, 32'h0, 1, 1'b0, ns, nr, a, wd, we, be, done);
      n_cmp++; if (ns !== 0 || nr !== 0) begin n_fail++;
         $display("FAIL mis_noreq: got stall %0d req %0d expected 0 0", ns, nr); end
      n_cmp++; if ({addr_err_o, rw_en_o, bus_err_o} !== 3'b100) begin n_fail++;
         $display("FAIL mis_wb: got %b expected 100", {addr_err_o, rw_en_o, bus_err_o}); end
      op_i = OP_NOP; F_i = 32'h55; rw_en_i = 1'b1;
      @(negedge clk);
      n_cmp++; if ({addr_err_o, rw_en_o} !== 2'b01) begin n_fail++;
         $display("FAIL mis_clear: got %b expected 01", {addr_err_o, rw_en_o}); end
   endtask

   task automatic test_timeout;
      int ns, nr; logic [31:0] a, wd; logic we; logic [3:0] be; bit done;
      run_mem(OP_LW, 32'h400, 32'h0, 32'h0, 0, 1'b0, ns, nr, a, wd, we, be, done);
      n_cmp++; if (nr !== 16 || ns !== 17) begin n_fail++;
         $display("FAIL to_cycles: got req %0d stall %0d expected 16 17", nr, ns); end
      n_cmp++; if ({bus_err_o, rw_en_o, addr_err_o} !== 3'b100) begin n_fail++;
         $display("FAIL to_wb: got %b expected 100", {bus_err_o, rw_en_o, addr_err_o}); end
      run_mem(OP_LW, 32'h404, 32'h0, 32'h0BADF00D, 16, 1'b0, ns, nr, a, wd, we, be, done);
      n_cmp++; if ({bus_err_o, rw_en_o, wdata_o} !== {2'b01, 32'h0BADF00D} || nr !== 16) begin n_fail++;
         $display("FAIL to_ack_wins: got %h req %0d expected %h 16", {bus_err_o, rw_en_o, wdata_o}, nr, {2'b01, 32'h0BADF00D}); end
   endtask

   task automatic test_reset_mid;
      @(negedge clk);
      op_i = OP_LW; F_i = 32'h300; rw_en_i = 1'b1; rw_i = 5'd7;
      @(negedge clk);
      n_cmp++; if (dmem_req_o !== 1'b1) begin n_fail++;
         $display("FAIL rst_mid_req: got %b expected 1", dmem_req_o); end
      #2 rst_n = 1'b0; op_i = OP_NOP; rw_en_i = 1'b0; F_i = '0;
      #1;
      n_cmp++; if ({dmem_req_o, dmem_addr_o, rw_en_o, wdata_o, stallreq_o} !== 67'h0) begin n_fail++;
         $display("FAIL rst_mid_clear: req %b addr %h rw_en %b wdata %h expected all 0", dmem_req_o, dmem_addr_o, rw_en_o, wdata_o); end
      @(negedge clk); rst_n = 1'b1;
      dmem_ack_i = 1'b1; dmem_rdata_i = 32'hFFFFFFFF;
      repeat (3) @(negedge clk);
      dmem_ack_i = 1'b0; dmem_rdata_i = '0;
      n_cmp++; if ({dmem_req_o, rw_en_o, wdata_o, bus_err_o} !== 35'h0) begin n_fail++;
         $display("FAIL rst_mid_after: got %h expected 0", {dmem_req_o, rw_en_o, wdata_o, bus_err_o}); end
   endtask

   task automatic test_stall_hold_bubble;
      @(negedge clk);
      op_i = OP_NOP; F_i = 32'hAAAA0001; rw_en_i = 1'b1; rw_i = 5'd3;
      @(negedge clk);
      stall4_tb = 1'b1; stall5_tb = 1'b1; F_i = 32'hBBBB0002; rw_i = 5'd4;
      @(negedge clk);
      n_cmp++; if ({rw_en_o, rw_o, wdata_o} !== {1'b1, 5'd3, 32'hAAAA0001}) begin n_fail++;
         $display("FAIL wb_hold: got %h expected %h", {rw_en_o, rw_o, wdata_o}, {1'b1, 5'd3, 32'hAAAA0001}); end
      stall5_tb = 1'b0;
      @(negedge clk);
      n_cmp++; if (rw_en_o !== 1'b0) begin n_fail++;
         $display("FAIL wb_bubble: got %b expected 0", rw_en_o); end
      stall4_tb = 1'b0; dmem_ack_i = 1'b1;
      #1;
      n_cmp++; if (stallreq_o !== 1'b0) begin n_fail++;
         $display("FAIL idle_ack_stall: got %b expected 0", stallreq_o); end
      @(negedge clk);
      dmem_ack_i = 1'b0;
      n_cmp++; if ({dmem_req_o, rw_en_o, rw_o, wdata_o} !== {2'b01, 5'd4, 32'hBBBB0002}) begin n_fail++;
         $display("FAIL idle_ack_pass: got %h expected %h", {dmem_req_o, rw_en_o, rw_o, wdata_o}, {2'b01, 5'd4, 32'hBBBB0002}); end
   endtask

   task automatic test_back_to_back;
      int ns, nr; logic [31:0] a, wd; logic we; logic [3:0] be; bit done;
      run_mem(OP_LW, 32'h500, 32'h0, 32'h11223344, 1, 1'b0, ns, nr, a, wd, we, be, done);
      n_cmp++; if (wdata_o !== 32'h11223344 || rw_en_o !== 1'b1) begin n_fail++;
         $display("FAIL b2b_first: got %h en %b expected 11223344 1", wdata_o, rw_en_o); end
      run_mem(OP_LBU, 32'h602, 32'h0, 32'h00990000, 2, 1'b1, ns, nr, a, wd, we, be, done);
      n_cmp++; if (ns !== 3 || a !== 32'h600 || wdata_o !== 32'h00000099) begin n_fail++;
         $display("FAIL b2b_second: got stall %0d addr %h data %h expected 3 600 00000099", ns, a, wdata_o); end
   endtask

   initial begin
      test_reset();
      test_passthrough();
      test_lw();
      test_byte_loads();
      test_stores();
      test_misaligned();
      test_timeout();
      test_reset_mid();
      test_stall_hold_bubble();
      test_back_to_back();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
